// File: rtl/boot_loader.sv
// boot_loader: streams a data image and a program image into the core's BRAMs,
// hands the data-BRAM write port to the core, releases the PC stall and runs
// the core for a bounded (or halt-terminated) number of cycles.
module boot_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned CNT_WIDTH  = ADDR_WIDTH - 1,
    parameter int unsigned RUN_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  d_count,
    input  logic [CNT_WIDTH-1:0]  i_count,
    input  logic [RUN_WIDTH-1:0]  run_cycles,
    input  logic                  halt,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] d_w_addr,
    output logic [DATA_WIDTH-1:0] d_w_dat,
    output logic                  d_w_enb,
    output logic [ADDR_WIDTH-1:0] i_w_addr,
    output logic [DATA_WIDTH-1:0] i_w_dat,
    output logic                  i_w_enb,
    output logic                  d_bram_init_done,
    output logic                  cpu_stall,
    output logic                  cpu_rd_enbl,
    output logic                  cpu_i_r_enb,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned IDX_WIDTH = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH     = 2 ** IDX_WIDTH;
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_D,
        LOAD_I,
        FLUSH,
        RUN,
        DONE,
        ERR
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CNT_WIDTH-1:0] d_cnt_q;
    logic [CNT_WIDTH-1:0] i_cnt_q;
    logic [CNT_WIDTH-1:0] idx;
    logic [CNT_WIDTH-1:0] cur_cnt;
    logic [RUN_WIDTH-1:0] run_q;
    logic [RUN_WIDTH-1:0] run_cnt;

    logic idle_like;
    logic range_bad;
    logic xfer;
    logic last_beat;
    logic run_last;

    assign idle_like = (state == IDLE) || (state == DONE) || (state == ERR);
    assign s_ready   = (state == LOAD_D) || (state == LOAD_I);
    assign busy      = !idle_like;
    assign xfer      = s_valid && s_ready;
    assign range_bad = (d_count > DEPTH_C) || (i_count > DEPTH_C);
    assign cur_cnt   = (state == LOAD_D) ? d_cnt_q : i_cnt_q;
    assign last_beat = (idx + CNT_WIDTH'(1)) == cur_cnt;
    assign run_last  = (run_q != '0) && (run_cnt == run_q - RUN_WIDTH'(1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    if (range_bad)            state_nx = ERR;
                    else if (d_count != '0)   state_nx = LOAD_D;
                    else if (i_count != '0)   state_nx = LOAD_I;
                    else                      state_nx = FLUSH;
                end
            end
            LOAD_D: begin
                if (xfer && last_beat) state_nx = (i_cnt_q != '0) ? LOAD_I : FLUSH;
            end
            LOAD_I: begin
                if (xfer && last_beat) state_nx = FLUSH;
            end
            FLUSH: state_nx = RUN;
            RUN: begin
                // halt wins over the cycle budget
                if (halt || run_last) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Counters, BRAM write ports and registered control outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_cnt_q          <= '0;
            i_cnt_q          <= '0;
            idx              <= '0;
            run_q            <= '0;
            run_cnt          <= '0;
            d_w_addr         <= '0;
            d_w_dat          <= '0;
            d_w_enb          <= 1'b0;
            i_w_addr         <= '0;
            i_w_dat          <= '0;
            i_w_enb          <= 1'b0;
            d_bram_init_done <= 1'b0;
            cpu_stall        <= 1'b1;
            cpu_rd_enbl      <= 1'b0;
            cpu_i_r_enb      <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
        end else begin
            d_w_enb     <= 1'b0;
            i_w_enb     <= 1'b0;
            // core controls follow the upcoming state so they are valid from the first RUN cycle
            cpu_stall   <= (state_nx != RUN);
            cpu_rd_enbl <= (state_nx == RUN);
            cpu_i_r_enb <= (state_nx == RUN);
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        if (range_bad) begin
                            err <= 1'b1;
                        end else begin
                            d_cnt_q          <= d_count;
                            i_cnt_q          <= i_count;
                            run_q            <= run_cycles;
                            idx              <= '0;
                            run_cnt          <= '0;
                            done             <= 1'b0;
                            err              <= 1'b0;
                            d_bram_init_done <= (d_count == '0);
                        end
                    end
                end
                LOAD_D: begin
                    if (xfer) begin
                        d_w_addr <= {idx[IDX_WIDTH-1:0], 2'b00};
                        d_w_dat  <= s_data;
                        d_w_enb  <= 1'b1;
                        idx      <= last_beat ? '0 : idx + CNT_WIDTH'(1);
                    end
                end
                LOAD_I: begin
                    // first LOAD_I edge is one past the final data write
                    d_bram_init_done <= 1'b1;
                    if (xfer) begin
                        i_w_addr <= {idx[IDX_WIDTH-1:0], 2'b00};
                        i_w_dat  <= s_data;
                        i_w_enb  <= 1'b1;
                        idx      <= last_beat ? '0 : idx + CNT_WIDTH'(1);
                    end
                end
                FLUSH: begin
                    d_bram_init_done <= 1'b1;
                    run_cnt          <= '0;
                end
                RUN: begin
                    d_bram_init_done <= 1'b1;
                    run_cnt          <= run_cnt + RUN_WIDTH'(1);
                    if (state_nx == DONE) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: accepted stream beats push the expected
// BRAM write; a negedge monitor pops and compares every write pulse.
module tb_boot_loader;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int CW    = 9;
    localparam int RW    = 32;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] d_count = '0;
    logic [CW-1:0] i_count = '0;
    logic [RW-1:0] run_cycles = '0;
    logic          halt = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic [AW-1:0] d_w_addr;
    logic [DW-1:0] d_w_dat;
    logic          d_w_enb;
    logic [AW-1:0] i_w_addr;
    logic [DW-1:0] i_w_dat;
    logic          i_w_enb;
    logic          d_bram_init_done;
    logic          cpu_stall;
    logic          cpu_rd_enbl;
    logic          cpu_i_r_enb;
    logic          busy;
    logic          done;
    logic          err;

    boot_loader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CW),
        .RUN_WIDTH (RW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .d_count          (d_count),
        .i_count          (i_count),
        .run_cycles       (run_cycles),
        .halt             (halt),
        .s_valid          (s_valid),
        .s_data           (s_data),
        .s_ready          (s_ready),
        .d_w_addr         (d_w_addr),
        .d_w_dat          (d_w_dat),
        .d_w_enb          (d_w_enb),
        .i_w_addr         (i_w_addr),
        .i_w_dat          (i_w_dat),
        .i_w_enb          (i_w_enb),
        .d_bram_init_done (d_bram_init_done),
        .cpu_stall        (cpu_stall),
        .cpu_rd_enbl      (cpu_rd_enbl),
        .cpu_i_r_enb      (cpu_i_r_enb),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } wr_t;

    wr_t dq[$];
    wr_t iq[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int   dw_cnt = 0;
    int   iw_cnt = 0;
    int   stall_low = 0;
    int   rd_en_cnt = 0;
    int   last_dw_cyc = -1;
    int   dbid_rise_cyc = -1;
    logic prev_dbid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor / scoreboard
    always @(negedge clk) begin
        wr_t e;
        if (d_w_enb === 1'b1) begin
            dw_cnt++;
            checks++;
            if (dq.size() == 0) begin
                failures++;
                $display("FAIL d_write_unexpected got addr=%h data=%h required no write", d_w_addr, d_w_dat);
            end else begin
                e = dq.pop_front();
                if (d_w_addr !== e.addr || d_w_dat !== e.data || cyc != e.cyc + 1) begin
                    failures++;
                    $display("FAIL d_write got addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                             d_w_addr, d_w_dat, cyc, e.addr, e.data, e.cyc + 1);
                end
            end
            checks++;
            if (d_bram_init_done !== 1'b0) begin
                failures++;
                $display("FAIL d_owner_during_write got %b required 0", d_bram_init_done);
            end
            last_dw_cyc = cyc;
        end
        if (i_w_enb === 1'b1) begin
            iw_cnt++;
            checks++;
            if (iq.size() == 0) begin
                failures++;
                $display("FAIL i_write_unexpected got addr=%h data=%h required no write", i_w_addr, i_w_dat);
            end else begin
                e = iq.pop_front();
                if (i_w_addr !== e.addr || i_w_dat !== e.data || cyc != e.cyc + 1) begin
                    failures++;
                    $display("FAIL i_write got addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                             i_w_addr, i_w_dat, cyc, e.addr, e.data, e.cyc + 1);
                end
            end
            checks++;
            if (cpu_stall !== 1'b1) begin
                failures++;
                $display("FAIL i_write_stall got cpu_stall=%b required 1", cpu_stall);
            end
        end
        if (rst === 1'b1 && cpu_stall === 1'b0) stall_low++;
        if (cpu_rd_enbl === 1'b1 && cpu_i_r_enb === 1'b1) rd_en_cnt++;
        if (d_bram_init_done === 1'b1 && prev_dbid === 1'b0) dbid_rise_cyc = cyc;
        prev_dbid = d_bram_init_done;
    end

    task automatic clear_stats();
        dw_cnt = 0; iw_cnt = 0; stall_low = 0; rd_en_cnt = 0;
        last_dw_cyc = -1; dbid_rise_cyc = -1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic do_start(input int dc, input int ic, input int rc);
        @(negedge clk);
        d_count    = CW'(dc);
        i_count    = CW'(ic);
        run_cycles = RW'(rc);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // pattern 0: valid every cycle; pattern 1: valid 1,0,0,1 repeating
    task automatic stream(input int n_d, input int limit, input int pattern);
        int   sent = 0;
        int   t = 0;
        logic v;
        wr_t  e;
        while (sent < limit) begin
            if (t > 3000) begin
                checks++;
                failures++;
                $display("FAIL stream_timeout sent=%0d required=%0d", sent, limit);
                break;
            end
            v = (pattern == 0) ? 1'b1 : ((t % 4) == 0 || (t % 4) == 3);
            s_valid = v;
            s_data  = $urandom;
            if (v && s_ready === 1'b1) begin
                e.data = s_data;
                e.cyc  = cyc;
                if (sent < n_d) begin
                    e.addr = AW'(4 * sent);
                    dq.push_back(e);
                end else begin
                    e.addr = AW'(4 * (sent - n_d));
                    iq.push_back(e);
                end
                sent++;
            end
            t++;
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        int t = 0;
        while (done !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        ok = (done === 1'b1);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({s_ready, d_w_enb, i_w_enb, d_bram_init_done, cpu_stall, cpu_rd_enbl,
             cpu_i_r_enb, busy, done, err} !== 10'b0000100000) begin
            failures++;
            $display("FAIL reset_ctrl got %b required 0000100000",
                     {s_ready, d_w_enb, i_w_enb, d_bram_init_done, cpu_stall, cpu_rd_enbl,
                      cpu_i_r_enb, busy, done, err});
        end
        checks++;
        if ({d_w_addr, d_w_dat, i_w_addr, i_w_dat} !== '0) begin
            failures++;
            $display("FAIL reset_ports got d_addr=%h d_dat=%h i_addr=%h i_dat=%h required 0",
                     d_w_addr, d_w_dat, i_w_addr, i_w_dat);
        end
        rst = 1'b1;
    endtask

    task automatic test_baseline();
        bit ok;
        clear_stats();
        do_start(3, 7, 7);
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b1 || d_bram_init_done !== 1'b0) begin
            failures++;
            $display("FAIL base_load_entry got busy=%b s_ready=%b dbid=%b required 1 1 0", busy, s_ready, d_bram_init_done);
        end
        stream(3, 10, 0);
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL base_done_timeout got done=%b required 1", done); end
        checks++;
        if (dw_cnt != 3 || iw_cnt != 7) begin
            failures++;
            $display("FAIL base_write_counts got d=%0d i=%0d required d=3 i=7", dw_cnt, iw_cnt);
        end
        checks++;
        if (dbid_rise_cyc != last_dw_cyc + 1) begin
            failures++;
            $display("FAIL base_dbid_rise got cyc=%0d required %0d", dbid_rise_cyc, last_dw_cyc + 1);
        end
        checks++;
        if (stall_low != 7 || rd_en_cnt != 7) begin
            failures++;
            $display("FAIL base_run_len got stall_low=%0d rd_en=%0d required 7 7", stall_low, rd_en_cnt);
        end
        checks++;
        if ({done, cpu_stall, busy, d_bram_init_done, cpu_rd_enbl} !== 5'b11010) begin
            failures++;
            $display("FAIL base_final got %b required 11010", {done, cpu_stall, busy, d_bram_init_done, cpu_rd_enbl});
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_stats();
        do_start(3, 7, 7);
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL bp_done_cleared got %b required 0", done); end
        stream(3, 10, 1);
        wait_done(ok);
        checks++;
        if (!ok || dw_cnt != 3 || iw_cnt != 7 || dq.size() != 0 || iq.size() != 0) begin
            failures++;
            $display("FAIL bp_writes got ok=%0d d=%0d i=%0d pend=%0d required 1 3 7 0", ok, dw_cnt, iw_cnt, dq.size() + iq.size());
        end
        checks++;
        if (dbid_rise_cyc != last_dw_cyc + 1 || stall_low != 7) begin
            failures++;
            $display("FAIL bp_handover got rise=%0d stall_low=%0d required %0d 7", dbid_rise_cyc, stall_low, last_dw_cyc + 1);
        end
    endtask

    task automatic test_empty_data();
        bit ok;
        apply_reset();
        clear_stats();
        do_start(0, 2, 3);
        checks++;
        if (d_bram_init_done !== 1'b1 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL empty_first_load_i got dbid=%b s_ready=%b required 1 1", d_bram_init_done, s_ready);
        end
        stream(0, 2, 0);
        wait_done(ok);
        checks++;
        if (!ok || dw_cnt != 0 || iw_cnt != 2 || iq.size() != 0) begin
            failures++;
            $display("FAIL empty_writes got ok=%0d d=%0d i=%0d required 1 0 2", ok, dw_cnt, iw_cnt);
        end
        checks++;
        if (stall_low != 3) begin failures++; $display("FAIL empty_run_len got %0d required 3", stall_low); end
    endtask

    task automatic test_range_error();
        bit ok;
        clear_stats();
        do_start(DEPTH + 1, 1, 5);
        checks++;
        if ({err, s_ready, cpu_stall, busy, done, d_bram_init_done} !== 6'b101011) begin
            failures++;
            $display("FAIL range_d got err,rdy,stall,busy,done,dbid=%b required 101011",
                     {err, s_ready, cpu_stall, busy, done, d_bram_init_done});
        end
        s_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (s_ready !== 1'b0 || cpu_stall !== 1'b1) begin
                failures++;
                $display("FAIL range_idle got s_ready=%b stall=%b required 0 1", s_ready, cpu_stall);
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        checks++;
        if (dw_cnt != 0 || iw_cnt != 0) begin
            failures++;
            $display("FAIL range_no_write got d=%0d i=%0d required 0 0", dw_cnt, iw_cnt);
        end
        do_start(1, DEPTH + 1, 5);
        checks++;
        if (err !== 1'b1 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL range_i got err=%b s_ready=%b required 1 0", err, s_ready);
        end
        do_start(1, 1, 2);
        checks++;
        if (err !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL range_clear got err=%b done=%b required 0 0", err, done);
        end
        stream(1, 2, 0);
        wait_done(ok);
        checks++;
        if (!ok || stall_low != 2 || dw_cnt != 1 || iw_cnt != 1) begin
            failures++;
            $display("FAIL range_recover got ok=%0d stall_low=%0d d=%0d i=%0d required 1 2 1 1", ok, stall_low, dw_cnt, iw_cnt);
        end
    endtask

    task automatic test_full_depth();
        bit ok;
        clear_stats();
        do_start(DEPTH, 1, 1);
        stream(DEPTH, DEPTH + 1, 0);
        wait_done(ok);
        checks++;
        if (!ok || dw_cnt != DEPTH || iw_cnt != 1 || last_dw_cyc < 0 || dq.size() != 0) begin
            failures++;
            $display("FAIL full_depth got ok=%0d d=%0d i=%0d required 1 %0d 1", ok, dw_cnt, iw_cnt, DEPTH);
        end
        checks++;
        if (d_w_addr !== 10'h3FC) begin
            failures++;
            $display("FAIL full_depth_top_addr got %h required 3fc", d_w_addr);
        end
    endtask

    task automatic test_halt();
        int t = 0;
        clear_stats();
        do_start(1, 1, 0);
        stream(1, 2, 0);
        while (cpu_stall !== 1'b0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (cpu_stall !== 1'b0) begin failures++; $display("FAIL halt_run_entry got stall=%b required 0", cpu_stall); end
        repeat (19) @(negedge clk);
        checks++;
        if (done !== 1'b0 || cpu_stall !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL halt_unbounded got done=%b stall=%b busy=%b required 0 0 1", done, cpu_stall, busy);
        end
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        checks++;
        if (cpu_stall !== 1'b1 || done !== 1'b1 || stall_low != 20) begin
            failures++;
            $display("FAIL halt_stop got stall=%b done=%b stall_low=%0d required 1 1 20", cpu_stall, done, stall_low);
        end
    endtask

    task automatic test_reset_mid_load();
        bit ok;
        clear_stats();
        do_start(3, 2, 4);
        stream(3, 2, 0);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({s_ready, d_w_enb, i_w_enb, d_bram_init_done, cpu_stall, cpu_rd_enbl,
             cpu_i_r_enb, busy, done, err} !== 10'b0000100000 ||
            {d_w_addr, d_w_dat, i_w_addr, i_w_dat} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got ctrl=%b d_addr=%h required ctrl=0000100000 zeros",
                     {s_ready, d_w_enb, i_w_enb, d_bram_init_done, cpu_stall, cpu_rd_enbl,
                      cpu_i_r_enb, busy, done, err}, d_w_addr);
        end
        checks++;
        if (dw_cnt != 2) begin failures++; $display("FAIL midreset_partial got %0d required 2", dw_cnt); end
        @(negedge clk);
        rst = 1'b1;
        dq.delete();
        iq.delete();
        clear_stats();
        do_start(3, 2, 4);
        stream(3, 5, 0);
        wait_done(ok);
        checks++;
        if (!ok || dw_cnt != 3 || iw_cnt != 2 || stall_low != 4 || dq.size() != 0 || iq.size() != 0) begin
            failures++;
            $display("FAIL midreset_reload got ok=%0d d=%0d i=%0d stall_low=%0d required 1 3 2 4", ok, dw_cnt, iw_cnt, stall_low);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_baseline();
        test_backpressure();
        test_empty_data();
        test_range_error();
        test_full_depth();
        test_halt();
        test_reset_mid_load();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
